// File: rtl/neuron_accumulator_if.sv
// rtl/neuron_accumulator_if.sv - layer-controller <-> neuron accumulator signal bundle
//
// Purpose: groups the product stream, neuron control and activation result
// of one neuron accumulator.
// Signals:
//   start      controller -> acc  begin a new neuron, bias sampled with it
//   bias       controller -> acc  sign-magnitude bias word
//   prod_valid controller -> acc  prod_in carries a product this cycle
//   prod_in    controller -> acc  sign-magnitude product word
//   relu_en    controller -> acc  clamp negative results to zero
//   busy       acc -> controller  neuron in progress
//   out_valid  acc -> controller  one-cycle result strobe
//   out_data   acc -> controller  sign-magnitude activation
//   overflow   acc -> controller  sticky: last result saturated
interface neuron_accumulator_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] bias;
  logic                  prod_valid;
  logic [DATA_WIDTH-1:0] prod_in;
  logic                  relu_en;
  logic                  busy;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  overflow;

  modport master (
    output start, bias, prod_valid, prod_in, relu_en,
    input  busy, out_valid, out_data, overflow
  );

  modport slave (
    input  start, bias, prod_valid, prod_in, relu_en,
    output busy, out_valid, out_data, overflow
  );
endinterface

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums one neuron's products plus bias, saturates, optional ReLU
//
// Purpose: collects NUM_INPUTS sign-magnitude products from the bit-serial
// multiplier into a two's-complement accumulator seeded with the bias, then
// saturates to the sign-magnitude word range, optionally clamps negatives to
// zero and presents the activation with a one-cycle out_valid strobe.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    neuron_accumulator_if.slave (start/bias/prod_valid/prod_in/relu_en in,
//          busy/out_valid/out_data/overflow out)
module neuron_accumulator #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 10,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  neuron_accumulator_if.slave  bus
);

  localparam int MAG_W = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);
  // Largest representable magnitude; the range is symmetric because the
  // output is sign-magnitude.
  localparam logic signed [ACC_WIDTH-1:0] SAT_POS =
    signed'({{(ACC_WIDTH - MAG_W){1'b0}}, {MAG_W{1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_NEG = -SAT_POS;

  // The accumulator is sized so it can never wrap; reject parameter sets
  // that would break that guarantee or the word format.
  if (NUM_INPUTS < 1 || FRAC_WIDTH >= DATA_WIDTH ||
      ACC_WIDTH < DATA_WIDTH + $clog2(NUM_INPUTS + 1)) begin : g_param_check
    $error("neuron_accumulator: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FINISH = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_W-1:0]             cnt;
  logic                         busy_q;
  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic                         ovf_q;

  // Sign-magnitude to two's complement; 0x8000 maps to plain zero.
  function automatic logic signed [ACC_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] w);
    logic signed [ACC_WIDTH-1:0] m;
    m = signed'({{(ACC_WIDTH - MAG_W){1'b0}}, w[MAG_W-1:0]});
    return w[DATA_WIDTH-1] ? -m : m;
  endfunction

  // Result formatting used in FINISH: saturate, ReLU, canonical zero.
  logic                  res_neg;
  logic [MAG_W-1:0]      res_mag;
  logic                  res_sat;
  logic [DATA_WIDTH-1:0] res_word;

  always_comb begin
    res_neg = 1'b0;
    res_mag = '0;
    res_sat = 1'b0;
    if (acc > SAT_POS) begin
      res_mag = '1;
      res_sat = 1'b1;
    end else if (acc < SAT_NEG) begin
      res_neg = 1'b1;
      res_mag = '1;
      res_sat = 1'b1;
    end else begin
      res_neg = acc[ACC_WIDTH-1];
      res_mag = MAG_W'(acc[ACC_WIDTH-1] ? -acc : acc);
    end
    // ReLU clears the value but leaves the saturation flag as computed.
    if (res_neg && bus.relu_en) begin
      res_neg = 1'b0;
      res_mag = '0;
    end
    if (res_mag == '0) begin
      res_neg = 1'b0;
    end
    res_word = {res_neg, res_mag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc    <= conv(bus.bias);
            cnt    <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.prod_valid) begin
            acc <= acc + conv(bus.prod_in);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          out_data_q  <= res_word;
          ovf_q       <= res_sat;
          out_valid_q <= 1'b1;
          state       <= S_OUTPUT;
        end
        S_OUTPUT: begin
          // start seen here is dropped; it is honoured from the next cycle.
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - self-checking bench for neuron_accumulator
module tb_neuron_accumulator;
  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neuron_accumulator_if #(.DATA_WIDTH(DW)) bus ();

  neuron_accumulator #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(10),
    .ACC_WIDTH (24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]         bias;
    logic [N-1:0][15:0]  p;
    logic                relu;
    logic [15:0]         exp_data;
    logic                exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sm(input logic [15:0] w);
    return w[15] ? -int'(w[14:0]) : int'(w[14:0]);
  endfunction

  // Plain-integer reference: sum, clamp to +-32767, ReLU, encode sign-magnitude.
  function automatic logic [16:0] model(input logic [15:0] b, input logic [N-1:0][15:0] p,
                                        input logic relu);
    int sum;
    logic ovf;
    logic [15:0] d;
    sum = sm(b);
    for (int i = 0; i < N; i++) sum += sm(p[i]);
    ovf = 1'b0;
    if (sum > 32767) begin sum = 32767; ovf = 1'b1; end
    if (sum < -32767) begin sum = -32767; ovf = 1'b1; end
    if (relu && sum < 0) sum = 0;
    d = (sum < 0) ? {1'b1, 15'(-sum)} : {1'b0, 15'(sum)};
    return {ovf, d};
  endfunction

  task automatic run_neuron(input logic [15:0] b, input logic [N-1:0][15:0] p, input logic relu,
                            input logic [15:0] exp_data, input logic exp_ovf,
                            input int max_gap, input bit junk, input string tag);
    bus.start = 1'b1;
    bus.bias = b;
    bus.relu_en = relu;
    step();
    bus.start = 1'b0;
    check({tag, " busy after start"}, 32'(bus.busy), 1);
    check({tag, " overflow cleared on start"}, 32'(bus.overflow), 0);
    for (int i = 0; i < N; i++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gaps) begin
        bus.prod_valid = 1'b0;
        bus.start = junk ? 1'($urandom % 2) : 1'b0;
        bus.bias = junk ? 16'($urandom) : b;
        step();
      end
      bus.start = 1'b0;
      bus.prod_valid = 1'b1;
      bus.prod_in = p[i];
      step();
      bus.prod_valid = 1'b0;
      bus.prod_in = 16'($urandom);
      if (i < N - 1) check({tag, " no early out_valid"}, 32'(bus.out_valid), 0);
    end
    check({tag, " out_valid low in finish"}, 32'(bus.out_valid), 0);
    check({tag, " busy in finish"}, 32'(bus.busy), 1);
    bus.prod_valid = junk;
    step();
    bus.prod_valid = 1'b0;
    check({tag, " out_valid 2 cycles after last"}, 32'(bus.out_valid), 1);
    check({tag, " out_data"}, 32'(bus.out_data), 32'(exp_data));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    bus.start = junk;
    bus.bias = 16'($urandom);
    step();
    bus.start = 1'b0;
    check({tag, " out_valid single cycle"}, 32'(bus.out_valid), 0);
    check({tag, " idle after output"}, 32'(bus.busy), 0);
    check({tag, " out_data held"}, 32'(bus.out_data), 32'(exp_data));
  endtask

  task automatic idle_junk();
    repeat ($urandom_range(0, 3)) begin
      bus.prod_valid = 1'b1;
      bus.prod_in = 16'($urandom);
      step();
    end
    bus.prod_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0][15:0] rp;
    logic [16:0] m;
    logic [15:0] rb;
    logic rr;

    vecs[0] = '{16'h0000, {16'h0200, 16'h8400, 16'h0800, 16'h0400}, 1'b0, 16'h0A00, 1'b0};
    vecs[1] = '{16'h8C00, {16'h0000, 16'h0000, 16'h0000, 16'h0400}, 1'b0, 16'h8800, 1'b0};
    vecs[2] = '{16'h8C00, {16'h0000, 16'h0000, 16'h0000, 16'h0400}, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{16'h0000, {16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00}, 1'b0, 16'h7FFF, 1'b1};
    vecs[4] = '{16'h0000, {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, 1'b0, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8000, {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h0000, {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, 1'b1, 16'h0000, 1'b1};
    vecs[7] = '{16'h0400, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 16'h0400, 1'b0};

    reset = 1'b0;
    bus.start = 1'b0;
    bus.bias = '0;
    bus.prod_valid = 1'b0;
    bus.prod_in = '0;
    bus.relu_en = 1'b0;
    step();
    step();
    check("reset busy", 32'(bus.busy), 0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset out_data", 32'(bus.out_data), 0);
    check("reset overflow", 32'(bus.overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Back-to-back products, then the same vectors with gaps and ignored starts.
    for (int v = 0; v < 8; v++)
      run_neuron(vecs[v].bias, vecs[v].p, vecs[v].relu, vecs[v].exp_data, vecs[v].exp_ovf,
                 0, 1'b0, $sformatf("vec%0d", v));
    for (int v = 0; v < 8; v++) begin
      idle_junk();
      run_neuron(vecs[v].bias, vecs[v].p, vecs[v].relu, vecs[v].exp_data, vecs[v].exp_ovf,
                 5, 1'b1, $sformatf("gapvec%0d", v));
    end

    // Reset mid-neuron after two products, following a non-zero result.
    run_neuron(vecs[0].bias, vecs[0].p, 1'b0, 16'h0A00, 1'b0, 0, 1'b0, "pre_reset");
    bus.start = 1'b1;
    bus.bias = 16'h0000;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod_in = 16'h0400;
      step();
    end
    bus.prod_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async reset busy", 32'(bus.busy), 0);
    check("async reset out_valid", 32'(bus.out_valid), 0);
    check("async reset out_data", 32'(bus.out_data), 0);
    check("async reset overflow", 32'(bus.overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    run_neuron(vecs[7].bias, vecs[7].p, 1'b0, 16'h0400, 1'b0, 0, 1'b0, "after_reset");

    // Randomized neurons against the integer model.
    for (int t = 0; t < 40; t++) begin
      rb = {1'($urandom), 15'($urandom_range(0, 16'h3FFF))};
      for (int i = 0; i < N; i++)
        rp[i] = (t % 4 == 0) ? 16'($urandom)
                             : {1'($urandom), 15'($urandom_range(0, 16'h1FFF))};
      rr = 1'($urandom);
      m = model(rb, rp, rr);
      idle_junk();
      run_neuron(rb, rp, rr, m[15:0], m[16], 5, 1'b1, $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
